// File: rtl/insr_imm_encoder.sv
// RV32I instruction packer: fields + immediate -> 32-bit word with range check, behind a 2-entry FIFO.
// Optional round-trip immediate self-check enabled by defining INSR_IMM_ENCODER_ROUNDTRIP_EN.
`ifndef INSR_LEN
`define INSR_LEN 32
`endif

module insr_imm_encoder #(
    parameter int DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           fmt_i,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [`INSR_LEN-1:0] imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [`INSR_LEN-1:0] out_insr_o,
    output logic                 out_err_o,
    output logic                 out_mismatch_o
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [`INSR_LEN-1:0] insr;
        logic                 err;
        logic                 mismatch;
    } entry_t;

    logic [`INSR_LEN-1:0] enc_insr;
    logic                 enc_err;
    logic                 enc_mismatch;
    logic                 fits12, fits13, fits21;

    assign fits12 = (imm_i == {{20{imm_i[11]}}, imm_i[11:0]});
    assign fits13 = (imm_i == {{19{imm_i[12]}}, imm_i[12:0]});
    assign fits21 = (imm_i == {{11{imm_i[20]}}, imm_i[20:0]});

    always_comb begin
        // NOTE: every signal written here gets a default first, so no case path can leave a latch behind.
        enc_insr = '0;
        enc_err  = 1'b0;
        case (fmt_i)
            FMT_R: enc_insr = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                enc_insr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = !fits12;
            end
            FMT_S: begin
                enc_insr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = !fits12;
            end
            FMT_B: begin
                enc_insr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = !fits13 || imm_i[0];
            end
            FMT_U: begin
                enc_insr = {imm_i[31:12], rd_i, opcode_i};
                enc_err  = (imm_i[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_insr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_err  = !fits21 || imm_i[0];
            end
            default: enc_err = 1'b1;
        endcase
    end

`ifdef INSR_IMM_ENCODER_ROUNDTRIP_EN
    logic [`INSR_LEN-1:0] dec_imm;

    // Immediate-generator decode keyed purely on the opcode bits of the packed word.
    always_comb begin
        dec_imm = '0;
        if (enc_insr[4:2] == 3'b101)
            dec_imm = {enc_insr[31:12], 12'd0};
        else if (enc_insr[3:2] == 2'b11)
            dec_imm = {{12{enc_insr[31]}}, enc_insr[19:12], enc_insr[20], enc_insr[30:21], 1'b0};
        else if (enc_insr[4:2] == 3'b001 || {enc_insr[6:5], enc_insr[3:2]} == 4'b0000)
            dec_imm = {{20{enc_insr[31]}}, enc_insr[31:20]};
        else if (enc_insr[6:2] == 5'b01000)
            dec_imm = {{20{enc_insr[31]}}, enc_insr[31:25], enc_insr[11:7]};
        else if (enc_insr[6:2] == 5'b11000)
            dec_imm = {{20{enc_insr[31]}}, enc_insr[7], enc_insr[30:25], enc_insr[11:8], 1'b0};
    end

    assign enc_mismatch = !enc_err && (fmt_i != FMT_R) && (dec_imm != imm_i);
`else
    assign enc_mismatch = 1'b0;
`endif

    entry_t     new_entry, slot0, slot1;
    logic [1:0] count, count_d;
    logic       ready_q;
    logic       push, pop;

    assign new_entry = '{insr: enc_insr, err: enc_err, mismatch: enc_mismatch};
    assign push      = in_valid_i && ready_q;
    assign pop       = out_valid_o && out_ready_i;

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 2'd1;
            2'b01:   count_d = count - 2'd1;
            default: count_d = count;
        endcase
    end

    // Slot0 is always the head; a pop shifts slot1 forward so the outputs come straight from a register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_i) begin
            // NOTE: both storage slots are cleared on reset so an empty buffer presents all-zero outputs.
            slot0   <= '0;
            slot1   <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= new_entry;
                    else               slot1 <= new_entry;
                end
                2'b01: begin
                    slot0 <= slot1;
                    slot1 <= '0;
                end
                2'b11:   slot0 <= new_entry;
                default: ;
            endcase
            count   <= count_d;
            ready_q <= (count_d < 2'(DEPTH));
        end
    end

    assign in_ready_o     = ready_q;
    assign out_valid_o    = (count != 2'd0);
    assign out_insr_o     = slot0.insr;
    assign out_err_o      = slot0.err;
    assign out_mismatch_o = slot0.mismatch;

endmodule
